sub4_serial: RTL and testbench
==============================

SUB4_SERIAL -- requirements
Module: sub4_serial

Interface
REQ-001 Parameter: WIDTH, 4, operand and result width in bits; only 4 is supported and verified.
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: start  input  1  request to begin a subtraction; sampled each rising edge.
REQ-005 Port: A  input  WIDTH  minuend, unsigned; sampled only on an accepted start.
REQ-006 Port: B  input  WIDTH  subtrahend, unsigned; sampled only on an accepted start.
REQ-007 Port: diff  output  WIDTH  registered result, (A - B) mod 2^WIDTH.
REQ-008 Port: borrow_out  output  1  registered final borrow; 1 when A < B.
REQ-009 Port: busy  output  1  high while a subtraction is in progress.
REQ-010 Port: done  output  1  single-cycle pulse when diff and borrow_out are updated.

Function
REQ-011 The block SHALL compute A - B bit-serially, LSB first, one bit per clock, using a one-bit borrow flip-flop.
REQ-012 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-013 In IDLE with start=1, the block SHALL capture A and B into internal shift registers, clear the borrow and the 2-bit bit counter, and enter SHIFT.
REQ-014 In IDLE with start=0, the block SHALL remain in IDLE and hold all outputs.
REQ-015 Each SHIFT cycle SHALL take a = a_reg[0] and b = b_reg[0].
REQ-016 Each SHIFT cycle SHALL compute d = a^b^br and br_next = (~a&b) | (~(a^b)&br).
REQ-017 Each SHIFT cycle SHALL shift d into the MSB of the partial-result register, shift both operand registers right, and increment the counter.
REQ-018 After the WIDTH-th SHIFT cycle (counter = WIDTH-1), the FSM SHALL enter DONE.
REQ-019 On the transition into DONE, the block SHALL load diff from the completed partial result and borrow_out from br_next.
REQ-020 In DONE, done SHALL be 1 for exactly one cycle and busy SHALL be 0.
REQ-021 From DONE, start=1 SHALL be accepted exactly as in IDLE and go directly to SHIFT; start=0 SHALL return the FSM to IDLE.
REQ-022 busy SHALL be 1 exactly while the FSM is in SHIFT.
REQ-023 start SHALL be ignored while in SHIFT: no recapture of A or B and no effect on the in-flight result.
REQ-024 Latency SHALL be fixed: with start accepted at edge N, done=1 and diff/borrow_out are valid in the cycle after edge N+WIDTH, i.e. 5 cycles for WIDTH=4.
REQ-025 diff and borrow_out SHALL hold their last result until the next done pulse and SHALL NOT show partial values during SHIFT.
REQ-026 A and B SHALL be don't-care except on the accepting edge; changes during SHIFT SHALL NOT alter the result.
REQ-027 Wrap-around: A < B SHALL yield diff = A - B + 16 with borrow_out = 1; A >= B SHALL yield borrow_out = 0.
REQ-028 Throughput SHALL be one result per WIDTH+1 cycles when start is held high continuously.

Reset
REQ-029 With rst=1 at a rising edge, the block SHALL set the FSM to IDLE and clear diff, borrow_out, busy, done, the borrow flip-flop, the counter and the operand/partial registers to 0.
REQ-030 Reset SHALL take priority over start in the same cycle.
REQ-031 Reset asserted during SHIFT SHALL abort the operation with no done pulse and no change to diff other than the clear.
REQ-032 The first accepted start after rst deasserts SHALL behave as a normal start.

Verification
REQ-033 A=9, B=5, start for 1 cycle -> busy for 4 cycles, then done=1 with diff=4, borrow_out=0.
REQ-034 A=5, B=9 -> diff=12, borrow_out=1; A=0, B=1 -> diff=15, borrow_out=1; A=15, B=15 -> diff=0, borrow_out=0.
REQ-035 start pulsed with A=3, B=1, then A=0, B=7 and start=1 driven during SHIFT -> single done with diff=2, borrow_out=0; no second operation begins.
REQ-036 rst asserted in the 2nd SHIFT cycle of A=12, B=3 -> next cycle busy=0, done=0, diff=0, borrow_out=0, FSM in IDLE.
REQ-037 start held high with operand pairs (9,5) then (5,9) -> done pulses exactly 5 cycles apart, results (4,0) then (12,1).
REQ-038 Exhaustive sweep of all 256 A,B pairs -> diff = (A-B) mod 16 and borrow_out = (A<B) for every pair.

Source files
------------

// File: rtl/sub4_serial_if.sv
// Operand/result bundle for the bit-serial subtractor.
// The master drives start and the operands; the slave returns the result and status.
interface sub4_serial_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
  logic             busy;
  logic             done;

  modport master (
    output start, A, B,
    input  diff, borrow_out, busy, done
  );

  modport slave (
    input  start, A, B,
    output diff, borrow_out, busy, done
  );
endinterface

// File: rtl/sub4_serial.sv
// Bit-serial unsigned subtractor: computes A - B LSB first, one bit per clock,
// through a single borrow flip-flop; the result and final borrow are registered.
module sub4_serial #(
  parameter int WIDTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  sub4_serial_if.slave bus
);
  localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] part_q;
  logic [WIDTH-1:0] diff_q;
  logic [CW-1:0]    cnt_q;
  logic             br_q;
  logic             borrow_q;
  logic             busy_q;
  logic             done_q;

  logic             diff_bit_d;
  logic             br_d;
  logic [WIDTH-1:0] part_d;

  // One full-subtractor step on the current operand LSBs and the stored borrow.
  always_comb begin
    diff_bit_d = 1'b0;
    br_d       = 1'b0;
    part_d     = part_q;
    diff_bit_d = a_q[0] ^ b_q[0] ^ br_q;
    br_d       = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
    part_d     = {diff_bit_d, part_q[WIDTH-1:1]};
  end

  // Control FSM with datapath registers and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      part_q   <= '0;
      diff_q   <= '0;
      cnt_q    <= '0;
      br_q     <= 1'b0;
      borrow_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        // DONE accepts a new start exactly like IDLE, giving back-to-back throughput.
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            a_q     <= bus.A;
            b_q     <= bus.B;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        SHIFT: begin
          a_q    <= {1'b0, a_q[WIDTH-1:1]};
          b_q    <= {1'b0, b_q[WIDTH-1:1]};
          part_q <= part_d;
          br_q   <= br_d;
          cnt_q  <= cnt_q + CW'(1);
          if (cnt_q == LAST_CNT) begin
            diff_q   <= part_d;
            borrow_q <= br_d;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= DONE;
          end else begin
            busy_q   <= 1'b1;
            done_q   <= 1'b0;
            state_q  <= SHIFT;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.diff       = diff_q;
  assign bus.borrow_out = borrow_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
endmodule

// File: tb/tb_sub4_serial.sv
// Scoreboard bench for sub4_serial: stimulus pushes expected results with their due
// cycle, and an independent monitor pops and compares on every done pulse.
module tb_sub4_serial;
  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  typedef struct {
    logic [3:0] d;
    logic       b;
    int         due;
  } exp_t;

  exp_t sb[$];

  sub4_serial_if #(.WIDTH(4)) bus ();
  sub4_serial #(.WIDTH(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got done=1 expected no pending result (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("diff", 32'(bus.diff), 32'(e.d));
        chk("borrow_out", 32'(bus.borrow_out), 32'(e.b));
        chk("done_latency", 32'(cyc), 32'(e.due));
        chk("busy_in_done", 32'(bus.busy), 32'd0);
      end
    end
  end

  task automatic push(input logic [3:0] d, input logic b, input int due);
    exp_t e;
    e.d = d;
    e.b = b;
    e.due = due;
    sb.push_back(e);
  endtask

  // One single-cycle start; operands are scrambled during SHIFT and busy is checked.
  task automatic do_op(input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] ed, input logic eb);
    int c;
    c = cyc;
    bus.start = 1'b1;
    bus.A = a;
    bus.B = b;
    push(ed, eb, c + 5);
    @(negedge clk);
    bus.start = 1'b0;
    bus.A = 4'($urandom_range(15, 0));
    bus.B = 4'($urandom_range(15, 0));
    for (int i = 0; i < 4; i++) begin
      chk("busy_shift", 32'(bus.busy), 32'd1);
      chk("done_early", 32'(bus.done), 32'd0);
      @(negedge clk);
    end
    chk("busy_at_done", 32'(bus.busy), 32'd0);
    @(negedge clk);
    chk("done_single", 32'(bus.done), 32'd0);
    chk("sb_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] va [7];
    logic [3:0] vb [7];
    logic [3:0] vd [7];
    logic       vr [7];
    logic [4:0] r;
    int         c;

    va = '{4'd9, 4'd5, 4'd0, 4'd15, 4'd0, 4'd15, 4'd0};
    vb = '{4'd5, 4'd9, 4'd1, 4'd15, 4'd0, 4'd0, 4'd15};
    vd = '{4'd4, 4'd12, 4'd15, 4'd0, 4'd0, 4'd15, 4'd1};
    vr = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

    rst = 1'b1;
    bus.start = 1'b0;
    bus.A = 4'd0;
    bus.B = 4'd0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_diff", 32'(bus.diff), 32'd0);
    chk("rst_borrow", 32'(bus.borrow_out), 32'd0);

    // Reset wins over a simultaneous start.
    bus.start = 1'b1;
    bus.A = 4'd9;
    bus.B = 4'd5;
    @(negedge clk);
    chk("rst_prio_busy", 32'(bus.busy), 32'd0);
    rst = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    chk("idle_busy", 32'(bus.busy), 32'd0);

    for (int i = 0; i < 7; i++) do_op(va[i], vb[i], vd[i], vr[i]);

    // Abort in the second SHIFT cycle of 12-3; diff (1 from 0-15) must clear.
    chk("pre_abort_diff", 32'(bus.diff), 32'd1);
    bus.start = 1'b1;
    bus.A = 4'd12;
    bus.B = 4'd3;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    chk("abort_diff", 32'(bus.diff), 32'd0);
    chk("abort_borrow", 32'(bus.borrow_out), 32'd0);
    repeat (8) @(negedge clk);
    chk("abort_diff_hold", 32'(bus.diff), 32'd0);

    // start held high: (9,5) then (5,9), done pulses five cycles apart.
    c = cyc;
    bus.start = 1'b1;
    bus.A = 4'd9;
    bus.B = 4'd5;
    push(4'd4, 1'b0, c + 5);
    @(negedge clk);
    bus.A = 4'd5;
    bus.B = 4'd9;
    push(4'd12, 1'b1, c + 10);
    repeat (5) @(negedge clk);
    bus.start = 1'b0;
    repeat (6) @(negedge clk);
    chk("held_sb_empty", 32'(sb.size()), 32'd0);
    chk("held_hold_diff", 32'(bus.diff), 32'd12);

    // start re-driven during SHIFT with new operands must be ignored.
    c = cyc;
    bus.start = 1'b1;
    bus.A = 4'd3;
    bus.B = 4'd1;
    push(4'd2, 1'b0, c + 5);
    @(negedge clk);
    bus.A = 4'd0;
    bus.B = 4'd7;
    repeat (2) @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    chk("ignore_sb_empty", 32'(sb.size()), 32'd0);
    chk("ignore_busy", 32'(bus.busy), 32'd0);

    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        r = {1'b0, 4'(a)} - {1'b0, 4'(b)};
        do_op(4'(a), 4'(b), r[3:0], r[4]);
      end
    end

    repeat (4) @(negedge clk);
    chk("final_sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
